// File: rtl/pwm_ramp_ctrl_if.sv
// Command channel of pwm_ramp_ctrl: target duty and direction offered with a valid/ready handshake.
// The master offers a command; the slave (the ramp controller) takes it when valid and ready are both high.
interface pwm_ramp_ctrl_if #(
  parameter int CNT_W = 11
);
  logic             valid;
  logic             ready;
  logic [CNT_W-1:0] duty;
  logic             dir;

  modport master (output valid, output duty, output dir, input  ready);
  modport slave  (input  valid, input  duty, input  dir, output ready);
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle ramp sequencer for one motor channel; state, duty and direction move only on period boundaries.
// Optional watchdog that drops the target to 0 after a quiet spell: define PWM_WDOG_EN.
module pwm_ramp_ctrl #(
  parameter int CNT_W        = 11,
  parameter int STEP         = 16,
  parameter int MAX_DUTY     = 2047,
  parameter int DEAD_PERIODS = 4,
  parameter int WDOG_PERIODS = 64
) (
  input  logic             clk,
  input  logic             rst,
  pwm_ramp_ctrl_if.slave   cmd,
  output logic [CNT_W-1:0] pwm_count_o,
  output logic             dir_o,
  output logic             period_tick_o,
  output logic             busy_o,
  output logic             at_target_o,
  output logic             wdog_trip_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RAMP = 2'd1;
  localparam logic [1:0] S_DEAD = 2'd2;

  localparam int                      DEAD_W    = $clog2(DEAD_PERIODS + 1);
  localparam logic [DEAD_W-1:0]       DEAD_INIT = DEAD_W'(DEAD_PERIODS - 1);
  localparam logic [CNT_W-1:0]        MAX_D     = CNT_W'(MAX_DUTY);
  localparam logic [CNT_W-1:0]        STEP_U    = CNT_W'(STEP);
  localparam logic signed [CNT_W+1:0] STEP_S    = (CNT_W+2)'(STEP);

  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  pwm_q, pwm_d;
  logic [CNT_W-1:0]  tgt_duty_q, tgt_duty_d;
  logic              dir_q, dir_d;
  logic              tgt_dir_q, tgt_dir_d;
  logic [1:0]        state_q, state_d;
  logic [DEAD_W-1:0] dead_q, dead_d;
  logic [CNT_W-1:0]  goal;
  logic              tick;
  logic              accept;
  logic              wdog_fire;

  function automatic logic [CNT_W-1:0] sat_duty(input logic [CNT_W-1:0] d);
    return (d > MAX_D) ? MAX_D : d;
  endfunction

  // Signed distance to the goal decides the step, so the sum never leaves the CNT_W range.
  function automatic logic [CNT_W-1:0] step_toward(input logic [CNT_W-1:0] c,
                                                    input logic [CNT_W-1:0] g);
    logic signed [CNT_W+1:0] diff;
    diff = $signed({2'b00, g}) - $signed({2'b00, c});
    if (diff > STEP_S)
      return c + STEP_U;
    else if (diff < -STEP_S)
      return c - STEP_U;
    return g;
  endfunction

  assign tick      = (cnt_q == {CNT_W{1'b1}});
  assign cmd.ready = (state_q != S_DEAD);
  assign accept    = cmd.valid & cmd.ready;
  assign goal      = (tgt_dir_q == dir_q) ? tgt_duty_q : '0;

  always_comb begin
    pwm_d   = pwm_q;
    dir_d   = dir_q;
    state_d = state_q;
    dead_d  = dead_q;
    if (tick) begin
      case (state_q)
        S_DEAD: begin
          if (dead_q != '0) begin
            dead_d = dead_q - DEAD_W'(1);
          end else begin
            dir_d   = tgt_dir_q;
            state_d = (tgt_duty_q == '0) ? S_IDLE : S_RAMP;
          end
        end
        default: begin
          if ((dir_q != tgt_dir_q) && (pwm_q == '0)) begin
            state_d = S_DEAD;
            dead_d  = DEAD_INIT;
          end else begin
            pwm_d   = step_toward(pwm_q, goal);
            state_d = ((dir_q == tgt_dir_q) && (pwm_d == tgt_duty_q)) ? S_IDLE : S_RAMP;
          end
        end
      endcase
    end
  end

  // A command accepted on a tick edge is latched here while the tick itself used the old target.
  always_comb begin
    tgt_duty_d = tgt_duty_q;
    tgt_dir_d  = tgt_dir_q;
    if (accept) begin
      tgt_duty_d = sat_duty(cmd.duty);
      tgt_dir_d  = cmd.dir;
    end else if (wdog_fire) begin
      tgt_duty_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      pwm_q      <= '0;
      dir_q      <= 1'b0;
      tgt_duty_q <= '0;
      tgt_dir_q  <= 1'b0;
      state_q    <= S_IDLE;
      dead_q     <= '0;
    end else begin
      cnt_q      <= cnt_q + CNT_W'(1);
      pwm_q      <= pwm_d;
      dir_q      <= dir_d;
      tgt_duty_q <= tgt_duty_d;
      tgt_dir_q  <= tgt_dir_d;
      state_q    <= state_d;
      dead_q     <= dead_d;
    end
  end

`ifdef PWM_WDOG_EN
  localparam int               WDOG_W   = $clog2(WDOG_PERIODS + 1);
  localparam logic [WDOG_W-1:0] WDOG_TOP = WDOG_W'(WDOG_PERIODS);
  localparam logic [WDOG_W-1:0] WDOG_HIT = WDOG_W'(WDOG_PERIODS - 1);

  logic [WDOG_W-1:0] wdog_q;
  logic              trip_q;

  assign wdog_fire   = tick && !accept && (wdog_q == WDOG_HIT);
  assign wdog_trip_o = trip_q;

  // Tick count saturates at the limit so the trip fires once per quiet spell.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_q <= '0;
      trip_q <= 1'b0;
    end else if (accept) begin
      wdog_q <= '0;
      trip_q <= 1'b0;
    end else begin
      if (tick && (wdog_q != WDOG_TOP))
        wdog_q <= wdog_q + WDOG_W'(1);
      if (wdog_fire)
        trip_q <= 1'b1;
    end
  end
`else
  assign wdog_fire   = 1'b0;
  // Always 0; the comparison keeps the parameter list identical in both builds.
  assign wdog_trip_o = (WDOG_PERIODS < 0);
`endif

  assign pwm_count_o   = pwm_q;
  assign dir_o         = dir_q;
  assign period_tick_o = tick;
  assign busy_o        = (state_q != S_IDLE);
  assign at_target_o   = (dir_q == tgt_dir_q) && (pwm_q == tgt_duty_q);

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: ramp, reversal with dead time, retarget on a tick, saturation,
// async reset mid-ramp and the watchdog (behaviour selected by PWM_WDOG_EN).
module tb_pwm_ramp_ctrl;
  localparam int CW = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] pwm_count;
  logic          dir, period_tick, busy, at_target, wdog_trip;

  int n_chk  = 0;
  int n_fail = 0;
  int last_wait = 0;

  int t2_pwm [15] = '{84, 68, 52, 36, 20, 4, 0, 0, 0, 0, 0, 0, 16, 32, 48};
  int t4_pwm [4]  = '{80, 64, 48, 40};

  pwm_ramp_ctrl_if #(.CNT_W(CW)) cmd_if ();

  pwm_ramp_ctrl #(
    .CNT_W(CW), .STEP(16), .MAX_DUTY(200), .DEAD_PERIODS(4), .WDOG_PERIODS(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd          (cmd_if.slave),
    .pwm_count_o  (pwm_count),
    .dir_o        (dir),
    .period_tick_o(period_tick),
    .busy_o       (busy),
    .at_target_o  (at_target),
    .wdog_trip_o  (wdog_trip)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Returns #1 after the edge that consumed the next period tick.
  task automatic wait_tick();
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 600) begin
      @(negedge clk);
      n++;
      if (period_tick) seen = 1'b1;
    end
    last_wait = n;
    if (!seen) check_eq("tick_seen", 32'(seen), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input int duty, input bit d);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    @(negedge clk);
    cmd_if.valid = 1'b1;
    cmd_if.duty  = CW'(duty);
    cmd_if.dir   = d;
    while (!done && n < 3000) begin
      if (cmd_if.ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    cmd_if.valid = 1'b0;
    if (!done) check_eq("cmd_accepted", 32'(done), 1);
  endtask

  task automatic cmd_on_tick(input int duty, input bit d);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_tick && n < 600);
    if (!period_tick) check_eq("tick_seen_cmd", 32'(period_tick), 1);
    cmd_if.valid = 1'b1;
    cmd_if.duty  = CW'(duty);
    cmd_if.dir   = d;
    @(posedge clk);
    #1;
    cmd_if.valid = 1'b0;
  endtask

  initial begin
    cmd_if.valid = 1'b0;
    cmd_if.duty  = '0;
    cmd_if.dir   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_pwm", 32'(pwm_count), 0);
    check_eq("rst_dir", 32'(dir), 0);
    check_eq("rst_tick", 32'(period_tick), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_ready", 32'(cmd_if.ready), 1);
    check_eq("rst_at_target", 32'(at_target), 1);
    check_eq("rst_wdog", 32'(wdog_trip), 0);
    @(negedge clk);
    rst = 1'b0;

    // Ramp up from 0 to 100 in steps of 16
    send_cmd(100, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      wait_tick();
      check_eq($sformatf("t1_pwm_%0d", i), 32'(pwm_count), (i == 7) ? 100 : 16 * i);
      if (i == 1) check_eq("t1_busy_mid", 32'(busy), 1);
      if (i == 2) check_eq("t1_period_len", 32'(last_wait), 512);
    end
    check_eq("t1_busy_end", 32'(busy), 0);
    check_eq("t1_at_target", 32'(at_target), 1);

    // Reversal: ramp down, dead time with ready low, flip, ramp up
    send_cmd(48, 1'b1);
    for (int i = 1; i <= 15; i++) begin
      wait_tick();
      check_eq($sformatf("t2_pwm_%0d", i), 32'(pwm_count), 32'(t2_pwm[i-1]));
      check_eq($sformatf("t2_dir_%0d", i), 32'(dir), (i >= 12) ? 1 : 0);
      check_eq($sformatf("t2_ready_%0d", i), 32'(cmd_if.ready), (i >= 8 && i <= 11) ? 0 : 1);
      if (i == 9) begin
        @(negedge clk);
        cmd_if.valid = 1'b1;
        cmd_if.duty  = CW'(300);
        cmd_if.dir   = 1'b0;
        @(posedge clk);
        #1;
        cmd_if.valid = 1'b0;
      end
    end
    check_eq("t2_busy_end", 32'(busy), 0);
    check_eq("t2_at_target", 32'(at_target), 1);

    // Retarget accepted on the tick cycle: that tick still steps toward the old target
    send_cmd(500, 1'b1);
    wait_tick();
    check_eq("t4_pwm_64", 32'(pwm_count), 64);
    cmd_on_tick(40, 1'b1);
    check_eq("t4_pwm_0", 32'(pwm_count), 32'(t4_pwm[0]));
    for (int i = 1; i <= 3; i++) begin
      wait_tick();
      check_eq($sformatf("t4_pwm_%0d", i), 32'(pwm_count), 32'(t4_pwm[i]));
    end
    check_eq("t4_busy_end", 32'(busy), 0);
    check_eq("t4_at_target", 32'(at_target), 1);

    // Saturation: 511 requested, MAX_DUTY 200
    send_cmd(511, 1'b1);
    for (int i = 1; i <= 11; i++) begin
      wait_tick();
      check_eq($sformatf("t3_pwm_%0d", i), 32'(pwm_count), (40 + 16 * i > 200) ? 200 : 40 + 16 * i);
    end
    check_eq("t3_at_target", 32'(at_target), 1);
    check_eq("t3_busy_end", 32'(busy), 0);

    // Async reset in the middle of a ramp
    send_cmd(0, 1'b1);
    wait_tick();
    check_eq("t5_pwm_pre", 32'(pwm_count), 184);
    check_eq("t5_busy_pre", 32'(busy), 1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("t5_pwm", 32'(pwm_count), 0);
    check_eq("t5_dir", 32'(dir), 0);
    check_eq("t5_ready", 32'(cmd_if.ready), 1);
    check_eq("t5_tick", 32'(period_tick), 0);
    check_eq("t5_busy", 32'(busy), 0);
    check_eq("t5_at_target", 32'(at_target), 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Watchdog: no command after reaching 100
    send_cmd(100, 1'b0);
    for (int i = 1; i <= 23; i++) begin
      wait_tick();
      if (i == 7) check_eq("t6_pwm_hold", 32'(pwm_count), 100);
      if (i == 15) check_eq("t6_wdog_pre", 32'(wdog_trip), 0);
`ifdef PWM_WDOG_EN
      if (i == 16) begin
        check_eq("t6_wdog_trip", 32'(wdog_trip), 1);
        check_eq("t6_pwm_trip", 32'(pwm_count), 100);
      end
      if (i > 16)
        check_eq($sformatf("t6_pwm_%0d", i), 32'(pwm_count),
                 (100 - 16 * (i - 16) < 0) ? 0 : 100 - 16 * (i - 16));
`else
      if (i >= 16) begin
        check_eq($sformatf("t6_pwm_%0d", i), 32'(pwm_count), 100);
        check_eq($sformatf("t6_wdog_%0d", i), 32'(wdog_trip), 0);
      end
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
